// File: rtl/vga_timing_ctrl_if.sv
// Signal bundle between the VGA timing generator and its consumers.
// ena is a plain advance qualifier: no valid/ready, the generator never stalls its consumer.
interface vga_timing_ctrl_if;
  logic       ena;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic [1:0] h_state;
  logic [1:0] v_state;

  modport master (
    input  ena,
    output hsync, vsync, display_on, hpos, vpos,
    output line_start, frame_start, frame_cnt, h_state, v_state
  );

  modport slave (
    output ena,
    input  hsync, vsync, display_on, hpos, vpos,
    input  line_start, frame_start, frame_cnt, h_state, v_state
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel/line counters, porch/sync FSMs and frame counter.
// All sync/position outputs decode registered state; only the start pulses see ena.
module vga_timing_ctrl #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  vga_timing_ctrl_if.master     vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_FP_S = 10'(H_DISPLAY);
  localparam logic [9:0] H_SY_S = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_BP_S = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_FP_S = 10'(V_DISPLAY);
  localparam logic [9:0] V_SY_S = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_BP_S = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_timing_ctrl: H_TOTAL/V_TOTAL must fit in 10 bits");
  end

  typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

  h_state_t   h_state, h_state_nxt;
  v_state_t   v_state, v_state_nxt;
  logic [9:0] hpos, hpos_nxt;
  logic [9:0] vpos, vpos_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic       h_wrap, v_wrap;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_state   <= H_ACT;
      v_state   <= V_ACT;
      hpos      <= '0;
      vpos      <= '0;
      frame_cnt <= '0;
    end else begin
      h_state   <= h_state_nxt;
      v_state   <= v_state_nxt;
      hpos      <= hpos_nxt;
      vpos      <= vpos_nxt;
      frame_cnt <= frame_cnt_nxt;
    end
  end

  // Counters: vpos steps only on the pixel wrap, frame_cnt only on the double wrap.
  always_comb begin
    h_wrap        = (hpos == H_LAST);
    v_wrap        = (vpos == V_LAST);
    hpos_nxt      = hpos;
    vpos_nxt      = vpos;
    frame_cnt_nxt = frame_cnt;
    if (vga.ena) begin
      hpos_nxt = h_wrap ? '0 : hpos + 10'd1;
      if (h_wrap) begin
        vpos_nxt = v_wrap ? '0 : vpos + 10'd1;
        if (v_wrap) frame_cnt_nxt = frame_cnt + 8'd1;
      end
    end
  end

  // Each state is left on the last count before the next region's first count.
  always_comb begin
    h_state_nxt = h_state;
    if (vga.ena) begin
      case (h_state)
        H_ACT:   if (hpos == H_FP_S - 10'd1) h_state_nxt = H_FP;
        H_FP:    if (hpos == H_SY_S - 10'd1) h_state_nxt = H_SY;
        H_SY:    if (hpos == H_BP_S - 10'd1) h_state_nxt = H_BP;
        H_BP:    if (h_wrap)                 h_state_nxt = H_ACT;
        default:                             h_state_nxt = H_ACT;
      endcase
    end
  end

  always_comb begin
    v_state_nxt = v_state;
    if (vga.ena && h_wrap) begin
      case (v_state)
        V_ACT:   if (vpos == V_FP_S - 10'd1) v_state_nxt = V_FP;
        V_FP:    if (vpos == V_SY_S - 10'd1) v_state_nxt = V_SY;
        V_SY:    if (vpos == V_BP_S - 10'd1) v_state_nxt = V_BP;
        V_BP:    if (v_wrap)                 v_state_nxt = V_ACT;
        default:                             v_state_nxt = V_ACT;
      endcase
    end
  end

  assign vga.hpos        = hpos;
  assign vga.vpos        = vpos;
  assign vga.frame_cnt   = frame_cnt;
  assign vga.hsync       = (h_state == H_SY) ? SYNC_POL : ~SYNC_POL;
  assign vga.vsync       = (v_state == V_SY) ? SYNC_POL : ~SYNC_POL;
  assign vga.display_on  = (h_state == H_ACT) && (v_state == V_ACT);
  assign vga.line_start  = vga.ena && !reset && (hpos == '0);
  assign vga.frame_start = vga.ena && !reset && (hpos == '0) && (vpos == '0);
  assign vga.h_state     = h_state;
  assign vga.v_state     = v_state;

  function automatic h_state_t h_decode(input logic [9:0] p);
    if (p < H_FP_S)      return H_ACT;
    else if (p < H_SY_S) return H_FP;
    else if (p < H_BP_S) return H_SY;
    else                 return H_BP;
  endfunction

  function automatic v_state_t v_decode(input logic [9:0] p);
    if (p < V_FP_S)      return V_ACT;
    else if (p < V_SY_S) return V_FP;
    else if (p < V_BP_S) return V_SY;
    else                 return V_BP;
  endfunction

  // The FSM states are redundant with the counters; any disagreement is a design bug.
  a_state_matches_pos: assert property (@(posedge clk) disable iff (reset)
    (h_state == h_decode(hpos)) && (v_state == v_decode(vpos)));

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: full-size line timing on dut_a, reduced-raster frame timing on dut_b.
module tb_vga_timing_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  vga_timing_ctrl_if vga_a ();
  vga_timing_ctrl_if vga_b ();

  vga_timing_ctrl dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (vga_a.master)
  );

  // 7 clocks per line (act 0-3, fp 4, sync 5, bp 6), 5 lines per frame (sync on line 3)
  vga_timing_ctrl #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (vga_b.master)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int hs_low;
    int vs_low;
    int h;
    int v;

    rst_a = 1'b1;
    rst_b = 1'b1;
    vga_a.ena = 1'b1;
    vga_b.ena = 1'b0;
    step(3);

    // reset state, and reset overrides ena=0 on dut_b
    check("rst_hpos",   vga_a.hpos, 0);
    check("rst_vpos",   vga_a.vpos, 0);
    check("rst_fcnt",   vga_a.frame_cnt, 0);
    check("rst_hsync",  vga_a.hsync, 1);
    check("rst_vsync",  vga_a.vsync, 1);
    check("rst_disp",   vga_a.display_on, 1);
    check("rst_ls",     vga_a.line_start, 0);
    check("rst_fs",     vga_a.frame_start, 0);
    check("rst_b_hpos", vga_b.hpos, 0);
    check("rst_b_vpos", vga_b.vpos, 0);

    rst_a = 1'b0;
    #1;
    check("first_ls", vga_a.line_start, 1);
    check("first_fs", vga_a.frame_start, 1);

    // one full default line
    hs_low = 0;
    for (int i = 0; i < 800; i++) begin
      check("line_hpos",  vga_a.hpos, i);
      check("line_vpos",  vga_a.vpos, 0);
      check("line_hsync", vga_a.hsync, (i >= 656 && i < 752) ? 0 : 1);
      check("line_vsync", vga_a.vsync, 1);
      check("line_disp",  vga_a.display_on, (i < 640) ? 1 : 0);
      check("line_ls",    vga_a.line_start, (i == 0) ? 1 : 0);
      if (vga_a.hsync == 1'b0) hs_low++;
      step(1);
    end
    check("hsync_width", hs_low, 96);
    check("wrap_hpos",   vga_a.hpos, 0);
    check("wrap_vpos",   vga_a.vpos, 1);
    check("wrap_ls",     vga_a.line_start, 1);
    check("wrap_fs",     vga_a.frame_start, 0);

    // freeze at hpos 300
    step(300);
    check("pre_hold_hpos", vga_a.hpos, 300);
    vga_a.ena = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("hold_hpos", vga_a.hpos, 300);
      check("hold_vpos", vga_a.vpos, 1);
      check("hold_ls",   vga_a.line_start, 0);
      check("hold_fs",   vga_a.frame_start, 0);
    end
    vga_a.ena = 1'b1;
    step(1);
    check("resume_hpos", vga_a.hpos, 301);

    // reset mid-line
    rst_a = 1'b1;
    step(1);
    check("midrst_hpos", vga_a.hpos, 0);
    check("midrst_vpos", vga_a.vpos, 0);
    check("midrst_ls",   vga_a.line_start, 0);
    rst_a = 1'b0;
    #1;
    check("midrst_fs", vga_a.frame_start, 1);
    step(1);
    check("midrst_next_hpos", vga_a.hpos, 1);

    // dut_b: out of reset with ena=0 holds at 0 and suppresses pulses
    rst_b = 1'b0;
    step(1);
    check("b_frozen_hpos", vga_b.hpos, 0);
    check("b_frozen_ls",   vga_b.line_start, 0);
    check("b_frozen_fs",   vga_b.frame_start, 0);
    vga_b.ena = 1'b1;
    #1;
    check("b_start_fs", vga_b.frame_start, 1);

    // one full reduced frame
    vs_low = 0;
    for (int k = 0; k < 35; k++) begin
      h = k % 7;
      v = k / 7;
      check("frm_hpos",  vga_b.hpos, h);
      check("frm_vpos",  vga_b.vpos, v);
      check("frm_hsync", vga_b.hsync, (h == 5) ? 0 : 1);
      check("frm_vsync", vga_b.vsync, (v == 3) ? 0 : 1);
      check("frm_disp",  vga_b.display_on, (h < 4 && v < 2) ? 1 : 0);
      check("frm_fs",    vga_b.frame_start, (k == 0) ? 1 : 0);
      check("frm_fcnt",  vga_b.frame_cnt, 0);
      if (vga_b.vsync == 1'b0) vs_low++;
      step(1);
    end
    check("vsync_width", vs_low, 7);
    check("fwrap_hpos",  vga_b.hpos, 0);
    check("fwrap_vpos",  vga_b.vpos, 0);
    check("fwrap_fcnt",  vga_b.frame_cnt, 1);
    check("fwrap_fs",    vga_b.frame_start, 1);

    // reset during vertical sync
    step(26);
    check("pre_rst_vsync", vga_b.vsync, 0);
    check("pre_rst_hsync", vga_b.hsync, 0);
    rst_b = 1'b1;
    step(1);
    check("vrst_hpos",  vga_b.hpos, 0);
    check("vrst_vpos",  vga_b.vpos, 0);
    check("vrst_vsync", vga_b.vsync, 1);
    check("vrst_fcnt",  vga_b.frame_cnt, 0);
    check("vrst_fs",    vga_b.frame_start, 0);
    rst_b = 1'b0;
    #1;

    // 256 frames wrap the frame counter back to 0
    step(255 * 35);
    check("fcnt_255", vga_b.frame_cnt, 255);
    step(34);
    check("fcnt_last_h", vga_b.hpos, 6);
    check("fcnt_last_v", vga_b.vpos, 4);
    check("fcnt_hold",   vga_b.frame_cnt, 255);
    step(1);
    check("fcnt_wrap",    vga_b.frame_cnt, 0);
    check("fcnt_wrap_fs", vga_b.frame_start, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16: horizontal front-porch clocks.
REQ-003 SHALL have parameter H_SYNC, default 96: horizontal sync-pulse clocks.
REQ-004 SHALL have parameter H_BACK, default 48: horizontal back-porch clocks.
REQ-005 SHALL have parameter V_DISPLAY, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10: vertical front-porch lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vertical sync-pulse lines.
REQ-008 SHALL have parameter V_BACK, default 33: vertical back-porch lines.
REQ-009 SHALL have parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-010 SHALL have port clk  input  1  pixel clock; all logic rising-edge.
REQ-011 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-012 SHALL have port ena  input  1  advance enable; 0 freezes all state.
REQ-013 SHALL have port hsync  output  1  horizontal sync at SYNC_POL when asserted.
REQ-014 SHALL have port vsync  output  1  vertical sync at SYNC_POL when asserted.
REQ-015 SHALL have port display_on  output  1  high in the visible region only.
REQ-016 SHALL have port hpos  output  10  pixel column, 0..H_TOTAL-1.
REQ-017 SHALL have port vpos  output  10  line number, 0..V_TOTAL-1.
REQ-018 SHALL have port line_start  output  1  one-clock pulse when hpos==0 and ena=1.
REQ-019 SHALL have port frame_start  output  1  one-clock pulse when hpos==0, vpos==0, ena=1.
REQ-020 SHALL have port frame_cnt  output  8  completed-frame counter, wraps 255->0.

Function
REQ-021 H_TOTAL = sum of H_* (800), V_TOTAL = sum of V_* (525); all totals SHALL fit 10 bits.
REQ-022 Horizontal FSM SHALL have states H_ACT, H_FP, H_SY, H_BP, entered at hpos 0, H_DISPLAY, H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC respectively.
REQ-023 Vertical FSM SHALL have states V_ACT, V_FP, V_SY, V_BP with identical boundary rule on vpos.
REQ-024 When ena=1, hpos SHALL increment each clock; at H_TOTAL-1 it SHALL wrap to 0 and H FSM return to H_ACT.
REQ-025 vpos SHALL increment only on the clock where hpos wraps; at V_TOTAL-1 with hpos wrap it SHALL wrap to 0.
REQ-026 frame_cnt SHALL increment (mod 256) on the clock where both hpos and vpos wrap.
REQ-027 When ena=0, hpos, vpos, both FSMs and frame_cnt SHALL hold; line_start and frame_start SHALL be 0.
REQ-028 hsync SHALL equal SYNC_POL exactly while H FSM is H_SY, else ~SYNC_POL.
REQ-029 vsync SHALL equal SYNC_POL exactly while V FSM is V_SY, else ~SYNC_POL.
REQ-030 display_on SHALL be 1 iff H FSM is H_ACT and V FSM is V_ACT.
REQ-031 All outputs SHALL be decoded from registered state in the same cycle (zero latency vs hpos/vpos); no combinational path from ena to hsync/vsync/display_on/hpos/vpos.
REQ-032 FSM state and hpos/vpos SHALL never disagree; an FSM state/counter mismatch is a design error.

Reset
REQ-033 reset=1 at a clock edge SHALL force hpos=0, vpos=0, H_ACT, V_ACT, frame_cnt=0, regardless of ena.
REQ-034 Outputs during/after reset: hsync=~SYNC_POL, vsync=~SYNC_POL, display_on=1, line_start=0, frame_start=0 while reset=1.
REQ-035 Reset mid-line or mid-frame SHALL restart timing from pixel 0, line 0 on the first clock after reset deasserts.

Verification
REQ-036 Reset, ena=1: first cycle hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1; hpos=640 -> display_on=0.
REQ-037 Line timing: hsync=0 for hpos 656..751 (96 clocks); hpos 799 -> 0 with vpos 0 -> 1, line period 800 clocks.
REQ-038 Frame timing: vsync=0 on lines 490..491 (1600 clocks); frame period 420000 clocks; frame_cnt 0 -> 1 at wrap.
REQ-039 ena=0 for 50 clocks at hpos=300: hpos stays 300, no pulses; ena=1 resumes at 301.
REQ-040 reset asserted at hpos=700, vpos=491: next cycle hpos=0, vpos=0, vsync=1, frame_cnt=0.
REQ-041 Force frame_cnt to 255 via 256 frames (or reduced parameters, e.g. H=4/1/1/1, V=2/1/1/1): 256th wrap gives frame_cnt=0.
